// File: rtl/switch_pio_in_if.sv
// switch_pio_in_if: Avalon-MM slave bus bundle for switch_pio_in
interface switch_pio_in_if;
  logic [1:0] address;
  logic chipselect, read_n, write_n;
  logic [31:0] writedata, readdata;
  modport master(output address, chipselect, read_n, write_n, writedata, input readdata);
  modport slave(input address, chipselect, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/switch_pio_in.sv
// switch_pio_in: synchronized edge-capturing Avalon-MM input port with maskable irq
// Optional per-bit debounce filter enabled by SWITCH_PIO_DEBOUNCE_EN
module switch_pio_in #(
  parameter int WIDTH = 18,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE = 0,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             reset,
  switch_pio_in_if.slave   bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync, filt, prev_q, det, clr, ec_q, ec_d, mask_q;
  logic [2:0] warm_q;
  logic [31:0] rdata_q, rdata_d;
  logic irq_q, wr, rd;
  assign sync = sync_q[SYNC_STAGES-1];
`ifdef SWITCH_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [WIDTH-1:0][CW-1:0] cnt_q;
  logic [WIDTH-1:0] filt_q;
  assign filt = filt_q;
  // counter tracks how long sync has held a value different from filt
  always_ff @(posedge clk)
    if (reset) begin
      cnt_q <= '0;
      filt_q <= '0;
    end else
      for (int i = 0; i < WIDTH; i++)
        if (sync[i] == filt_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt_q[i] <= sync[i];
          cnt_q[i] <= '0;
        end else cnt_q[i] <= cnt_q[i] + 1'b1;
`else
  assign filt = sync;
`endif
  assign wr = bus.chipselect && !bus.write_n;
  assign rd = bus.chipselect && !bus.read_n;
  assign clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
  // warm-up masks the first filt transition out of reset
  assign det = (warm_q != 3'd0) ? '0 :
               EDGE_TYPE == 0 ? filt & ~prev_q :
               EDGE_TYPE == 1 ? ~filt & prev_q : filt ^ prev_q;
  assign ec_d = (ec_q & ~clr) | det;
  assign rdata_d = bus.address == 2'd0 ? 32'(filt) :
                   bus.address == 2'd2 ? 32'(mask_q) :
                   bus.address == 2'd3 ? 32'(ec_q) : 32'd0;
  assign bus.readdata = rdata_q;
  assign irq = irq_q;
  always_ff @(posedge clk)
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
      ec_q <= '0;
      mask_q <= '0;
      rdata_q <= '0;
      irq_q <= 1'b0;
      warm_q <= 3'(SYNC_STAGES + 1);
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q <= filt;
      ec_q <= ec_d;
      if (wr && bus.address == 2'd2) mask_q <= bus.writedata[WIDTH-1:0];
      if (rd) rdata_q <= rdata_d;
      irq_q <= |(ec_q & mask_q);
      if (warm_q != 3'd0) warm_q <= warm_q - 3'd1;
    end
endmodule

// File: tb/tb_switch_pio_in.sv
// tb_switch_pio_in: scoreboard bench for switch_pio_in (debounce checks under SWITCH_PIO_DEBOUNCE_EN)
module tb_switch_pio_in;
  localparam int W = 18;
  logic clk = 1'b0, reset = 1'b1;
  logic [W-1:0] in_port = '0;
  logic irq;
  switch_pio_in_if bus();
  always #5 clk = ~clk;
`ifdef SWITCH_PIO_DEBOUNCE_EN
  switch_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(8)) dut(.clk(clk), .reset(reset), .bus(bus), .in_port(in_port), .irq(irq));
`else
  switch_pio_in #(.WIDTH(W)) dut(.clk(clk), .reset(reset), .bus(bus), .in_port(in_port), .irq(irq));
`endif
  typedef struct { string name; logic [31:0] v; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic rd_seen = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(posedge clk) rd_seen <= bus.chipselect === 1'b1 && bus.read_n === 1'b0;

  always @(negedge clk)
    if (rd_seen) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_read: got %h expected no read", bus.readdata);
      end else begin
        e = sb.pop_front();
        chk(e.name, bus.readdata, e.v);
      end
    end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] v, input string n);
    bus.address = a;
    bus.chipselect = 1'b1;
    bus.read_n = 1'b0;
    sb.push_back('{n, v});
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.read_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask

  task automatic rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] v, input string n);
    bus.address = a;
    bus.writedata = d;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    bus.read_n = 1'b0;
    sb.push_back('{n, v});
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.read_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.address = 2'd0;
    bus.chipselect = 1'b0;
    bus.read_n = 1'b1;
    bus.write_n = 1'b1;
    bus.writedata = '0;
`ifdef SWITCH_PIO_DEBOUNCE_EN
    in_port = '0;
`else
    in_port = '1;
`endif
    reset = 1'b1;
    cyc(2);
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_readdata", bus.readdata, 32'd0);
    reset = 1'b0;
    cyc(10);
`ifdef SWITCH_PIO_DEBOUNCE_EN
    in_port[0] = 1'b1;
    cyc(5);
    in_port[0] = 1'b0;
    cyc(15);
    rd(2'd0, 32'd0, "db_glitch_data");
    rd(2'd3, 32'd0, "db_glitch_capture");
    in_port[0] = 1'b1;
    cyc(12);
    cyc(3);
    rd(2'd0, 32'd1, "db_level_data");
    rd(2'd3, 32'd1, "db_level_capture");
`else
    rd(2'd3, 32'd0, "warmup_capture");
    chk("warmup_irq", 32'(irq), 32'd0);
    rd(2'd0, 32'h3FFFF, "data_all_high");
    in_port = '0;
    cyc(5);
    rd(2'd0, 32'd0, "data_low");
    rd(2'd3, 32'd0, "falling_ignored");
    wr(2'd2, 32'h4);
    in_port = 18'h5;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      chk($sformatf("irq_latency_%0d", i), 32'(irq), 32'(i == 4));
    end
    rd(2'd3, 32'h5, "capture_5");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h4, "w1c_bit0");
    chk("irq_after_w1c_bit0", 32'(irq), 32'd1);
    wr(2'd3, 32'h4);
    chk("irq_hold_clear_edge", 32'(irq), 32'd1);
    cyc(1);
    chk("irq_fall_after_clear", 32'(irq), 32'd0);
    rd(2'd3, 32'd0, "w1c_all");
    in_port = 18'h15;
    cyc(5);
    rd(2'd3, 32'h10, "bit4_rise");
    in_port = 18'h5;
    cyc(5);
    in_port = 18'h15;
    cyc(2);
    wr(2'd3, 32'h10);
    rd(2'd3, 32'h10, "set_wins_over_clear");
    wr(2'd3, 32'h10);
    in_port = 18'h17;
    cyc(2);
    rd(2'd3, 32'd0, "read_old_on_edge");
    rd(2'd3, 32'h2, "edge_visible_next");
    wr(2'd2, 32'hFFFFFFFF);
    rd(2'd1, 32'd0, "reserved_reads_0");
    rd(2'd2, 32'h3FFFF, "mask_readback");
    cyc(3);
    chk("readdata_hold", bus.readdata, 32'h3FFFF);
    chk("irq_all_mask", 32'(irq), 32'd1);
    rw(2'd2, 32'd0, 32'h3FFFF, "rw_pre_write");
    chk("irq_hold_mask_edge", 32'(irq), 32'd1);
    cyc(1);
    chk("irq_fall_mask_0", 32'(irq), 32'd0);
    rd(2'd2, 32'd0, "mask_cleared");
    rd(2'd3, 32'h2, "capture_kept");
    reset = 1'b1;
    rd(2'd3, 32'd0, "reset_aborts_read");
    reset = 1'b0;
    cyc(6);
    rd(2'd3, 32'd0, "post_reset_capture");
    rd(2'd0, 32'h17, "post_reset_data");
`endif
    for (int i = 0; i < 10 && sb.size() != 0; i++) cyc(1);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
